axi_read_responder: RTL and testbench
=====================================

// Module: axi_read_responder
// PURPOSE
// - AXI4 read-channel slave (AR in, R out) backed by an internal 64-bit-word memory; answers fetch master bursts.
// - Sits between the CPU fetch master and simulation memory; serves one burst at a time.
// - Preload write port fills memory before or between bursts.
// PARAMETERS
// ID_WIDTH    13          AXI ID width (arid/rid)
// ADDR_WIDTH  64          byte address width
// DATA_WIDTH  64          beat width; fixed at 64, other values unsupported
// DEPTH       4096        memory size in 64-bit words
// BASE_ADDR   64'h0       byte address of mem[0]
// PORTS
// clk            in   1           clock, all logic on posedge
// reset          in   1           synchronous, active-low reset
// s_axi_arid     in   ID_WIDTH    burst ID, echoed on rid
// s_axi_araddr   in   ADDR_WIDTH  start byte address
// s_axi_arlen    in   8           beats-1
// s_axi_arsize   in   3           log2 bytes per beat
// s_axi_arburst  in   2           0 FIXED, 1 INCR, 2 WRAP
// s_axi_arvalid  in   1           address valid
// s_axi_arready  out  1           address accepted
// s_axi_rid      out  ID_WIDTH    echoed arid
// s_axi_rdata    out  64          aligned 64-bit word containing beat address
// s_axi_rresp    out  2           00 OKAY, 10 SLVERR
// s_axi_rlast    out  1           final beat of burst
// s_axi_rvalid   out  1           beat valid
// s_axi_rready   in   1           master accepts beat
// mem_we         in   1           preload write enable
// mem_waddr      in   $clog2(DEPTH)  preload word index
// mem_wdata      in   64          preload data
// BEHAVIOUR
// - Reset (reset==0 at posedge): state IDLE; arready=0, rvalid=0, rlast=0, rresp=0, rid=0, rdata=0. Memory contents kept.
// - FSM IDLE: arready=1. arvalid&arready -> latch id/addr/len/size/burst, beat_cnt=0, goto BURST. arready=0 in BURST.
// - BURST: beat presented registered; first rvalid in cycle after AR handshake (latency 1).
// - Beat advance only on rvalid&rready; rdata/rresp/rlast/rid held stable while rvalid&!rready.
// - Last beat (beat_cnt==len) accepted -> IDLE; arready returns high next cycle (no back-to-back AR overlap).
// - Word index = (addr-BASE_ADDR)>>3; sub-word sizes return whole aligned word, no lane shifting.
// - Next addr: FIXED unchanged; INCR addr+(1<<size); WRAP: wrap_bytes=(len+1)<<size, addr wraps within aligned wrap_bytes window.
// - SLVERR (rdata=0) per beat: beat address outside [BASE_ADDR, BASE_ADDR+DEPTH*8).
// - SLVERR for whole burst: arsize>3; arburst==3; WRAP with len not in {1,3,7,15} or start unaligned to size. Burst still runs len+1 beats with rlast.
// - Address arithmetic ADDR_WIDTH bits, wraps modulo 2^ADDR_WIDTH; no 4KB-boundary check.
// - mem_we same cycle as read of same word: read returns old data (read-before-write).
// - reset low mid-burst: rvalid drops at that edge, burst abandoned, no rlast.
// STRUCTURE
// - Package axi_pkg: burst_t enum (FIXED/INCR/WRAP), RESP_OKAY/RESP_SLVERR constants, rd_state_t {IDLE,BURST}.
// - Sub-module axi_addr_gen: combinational next-address from addr/len/size/burst; unit-testable alone.
// - Top: FSM, latched AR regs, beat counter, memory array, R output registers.
// TESTING
// - Preload mem[k]=k*0x0101_0101_0101_0101; AR 0x40 len7 size3 INCR id5 -> 8 beats words 8..15, rid=5, rlast on beat 8 only.
// - AR 0x58 len3 size3 WRAP -> addrs 0x58,0x40,0x48,0x50 (words 11,8,9,10), all OKAY.
// - rready low 3 cycles on beat 2 -> rdata/rlast/rvalid unchanged, beat count not advanced.
// - AR BASE_ADDR+DEPTH*8-8 len1 INCR -> beat1 OKAY, beat2 SLVERR rdata=0, rlast on beat2.
// - AR len2 WRAP -> 3 beats all SLVERR; arsize=4 INCR -> all SLVERR.
// - reset low during beat 3 of 8 -> next cycle rvalid=0, arready=0; after release arready=1, new burst correct.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared types and constants for the AXI4 read responder.
// Covers burst encodings, response codes, FSM states and the WRAP length rule.
package axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2
  } burst_t;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } rd_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // WRAP bursts are only legal with 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    logic ok;
    case (len)
      8'd1, 8'd3, 8'd7, 8'd15: ok = 1'b1;
      default:                 ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/axi_addr_gen.sv
// Combinational next-beat address for FIXED / INCR / WRAP bursts.
// Arithmetic is modulo 2^ADDR_WIDTH; no 4KB boundary handling.
module axi_addr_gen
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 64
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [7:0]            len_i,
  input  logic [2:0]            size_i,
  input  logic [1:0]            burst_i,
  output logic [ADDR_WIDTH-1:0] next_addr_o
);

  localparam logic [ADDR_WIDTH-1:0] ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [ADDR_WIDTH-1:0] step_s;
  logic [ADDR_WIDTH-1:0] incr_s;
  logic [ADDR_WIDTH-1:0] wrap_mask_s;

  // Next address: WRAP keeps the upper bits of the aligned window and wraps the low bits.
  always_comb begin
    step_s      = ONE << size_i;
    incr_s      = addr_i + step_s;
    wrap_mask_s = (({{(ADDR_WIDTH-8){1'b0}}, len_i} + ONE) << size_i) - ONE;
    case (burst_i)
      BURST_FIXED: next_addr_o = addr_i;
      BURST_INCR:  next_addr_o = incr_s;
      BURST_WRAP:  next_addr_o = (addr_i & ~wrap_mask_s) | (incr_s & wrap_mask_s);
      default:     next_addr_o = addr_i;
    endcase
  end

endmodule

// File: rtl/axi_read_responder.sv
// AXI4 read-channel slave backed by an internal 64-bit word memory.
// One burst at a time; beats are registered, first beat one cycle after the AR handshake.
module axi_read_responder
  import axi_pkg::*;
#(
  parameter int                    ID_WIDTH   = 13,
  parameter int                    ADDR_WIDTH = 64,
  parameter int                    DATA_WIDTH = 64,
  parameter int                    DEPTH      = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = {ADDR_WIDTH{1'b0}}
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ID_WIDTH-1:0]      s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]    s_axi_araddr,
  input  logic [7:0]               s_axi_arlen,
  input  logic [2:0]               s_axi_arsize,
  input  logic [1:0]               s_axi_arburst,
  input  logic                     s_axi_arvalid,
  output logic                     s_axi_arready,
  output logic [ID_WIDTH-1:0]      s_axi_rid,
  output logic [DATA_WIDTH-1:0]    s_axi_rdata,
  output logic [1:0]               s_axi_rresp,
  output logic                     s_axi_rlast,
  output logic                     s_axi_rvalid,
  input  logic                     s_axi_rready,
  input  logic                     mem_we,
  input  logic [$clog2(DEPTH)-1:0] mem_waddr,
  input  logic [DATA_WIDTH-1:0]    mem_wdata
);

  localparam int                    IDX_W     = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ONE       = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(DEPTH) << 2'd3;

  rd_state_t             state_q;
  logic                  arready_q;
  logic                  rvalid_q;
  logic                  rlast_q;
  logic [1:0]            rresp_q;
  logic [ID_WIDTH-1:0]   rid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;
  logic                  err_q;
  logic [7:0]            beat_cnt_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] next_addr_s;
  logic [ADDR_WIDTH-1:0] ar_align_mask_s;
  logic                  ar_err_s;
  logic [ADDR_WIDTH-1:0] load_addr_d;
  logic                  burst_err_d;
  logic [ADDR_WIDTH-1:0] load_off_s;
  logic [IDX_W-1:0]      load_idx_s;
  logic [DATA_WIDTH-1:0] rdata_d;
  logic [1:0]            rresp_d;

  axi_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_gen (
    .addr_i      (addr_q),
    .len_i       (len_q),
    .size_i      (size_q),
    .burst_i     (burst_q),
    .next_addr_o (next_addr_s)
  );

  // Whole-burst error classification of the incoming AR request.
  always_comb begin
    ar_align_mask_s = (ONE << s_axi_arsize) - ONE;
    if (s_axi_arsize > 3'd3) begin
      ar_err_s = 1'b1;
    end else if (s_axi_arburst == 2'd3) begin
      ar_err_s = 1'b1;
    end else if (s_axi_arburst == BURST_WRAP) begin
      ar_err_s = !wrap_len_ok(s_axi_arlen) ||
                 ((s_axi_araddr & ar_align_mask_s) != {ADDR_WIDTH{1'b0}});
    end else begin
      ar_err_s = 1'b0;
    end
  end

  // Beat to load next: the AR start address from IDLE, otherwise the generated next address.
  always_comb begin
    if (state_q == IDLE) begin
      load_addr_d = s_axi_araddr;
      burst_err_d = ar_err_s;
    end else begin
      load_addr_d = next_addr_s;
      burst_err_d = err_q;
    end
    load_off_s = load_addr_d - BASE_ADDR;
    load_idx_s = load_off_s[IDX_W+2:3];
    if (burst_err_d || (load_off_s >= MEM_BYTES)) begin
      rresp_d = RESP_SLVERR;
      rdata_d = {DATA_WIDTH{1'b0}};
    end else begin
      rresp_d = RESP_OKAY;
      rdata_d = mem_q[load_idx_s];
    end
  end

  // Preload port; memory is not cleared by reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Read FSM with registered AR/R outputs and latched burst parameters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      rresp_q    <= RESP_OKAY;
      rid_q      <= {ID_WIDTH{1'b0}};
      rdata_q    <= {DATA_WIDTH{1'b0}};
      addr_q     <= {ADDR_WIDTH{1'b0}};
      len_q      <= 8'd0;
      size_q     <= 3'd0;
      burst_q    <= 2'd0;
      err_q      <= 1'b0;
      beat_cnt_q <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (s_axi_arvalid && arready_q) begin
            state_q    <= BURST;
            arready_q  <= 1'b0;
            addr_q     <= s_axi_araddr;
            len_q      <= s_axi_arlen;
            size_q     <= s_axi_arsize;
            burst_q    <= s_axi_arburst;
            err_q      <= ar_err_s;
            beat_cnt_q <= 8'd0;
            rid_q      <= s_axi_arid;
            rvalid_q   <= 1'b1;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            rlast_q    <= (s_axi_arlen == 8'd0);
          end else begin
            arready_q <= 1'b1;
          end
        end
        BURST: begin
          if (rvalid_q && s_axi_rready) begin
            if (beat_cnt_q == len_q) begin
              state_q   <= IDLE;
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
            end else begin
              addr_q     <= next_addr_s;
              beat_cnt_q <= beat_cnt_q + 8'd1;
              rdata_q    <= rdata_d;
              rresp_q    <= rresp_d;
              rlast_q    <= ((beat_cnt_q + 8'd1) == len_q);
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          arready_q <= 1'b0;
          rvalid_q  <= 1'b0;
          rlast_q   <= 1'b0;
        end
      endcase
    end
  end

  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rlast   = rlast_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rid     = rid_q;
  assign s_axi_rdata   = rdata_q;

endmodule

// File: tb/tb_axi_read_responder.sv
// Directed bench for axi_read_responder: bursts of each type, stalls, error cases,
// mid-burst reset and read-before-write on the preload port.
module tb_axi_read_responder;

  localparam int          IDW   = 13;
  localparam int          AW    = 64;
  localparam int          DEPTH = 4096;
  localparam logic [63:0] K     = 64'h0101_0101_0101_0101;

  logic            clk = 1'b0;
  logic            reset;
  logic [IDW-1:0]  arid;
  logic [AW-1:0]   araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            arvalid;
  logic            s_axi_arready;
  logic [IDW-1:0]  s_axi_rid;
  logic [63:0]     s_axi_rdata;
  logic [1:0]      s_axi_rresp;
  logic            s_axi_rlast;
  logic            s_axi_rvalid;
  logic            rready;
  logic            mem_we;
  logic [11:0]     mem_waddr;
  logic [63:0]     mem_wdata;

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] mem_model [DEPTH];
  logic [63:0] exp_addr  [16];
  logic        exp_err   [16];

  always #5 clk = ~clk;

  axi_read_responder dut (
    .clk           (clk),
    .reset         (reset),
    .s_axi_arid    (arid),
    .s_axi_araddr  (araddr),
    .s_axi_arlen   (arlen),
    .s_axi_arsize  (arsize),
    .s_axi_arburst (arburst),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rid     (s_axi_rid),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rlast   (s_axi_rlast),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (rready),
    .mem_we        (mem_we),
    .mem_waddr     (mem_waddr),
    .mem_wdata     (mem_wdata)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_exp(input int i, input logic [63:0] a, input logic e);
    exp_addr[i] = a;
    exp_err[i]  = e;
  endtask

  task automatic run_burst(input logic [IDW-1:0] id, input logic [63:0] addr,
                           input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input int stall_idx,
                           input int abort_idx, input logic rbw);
    int          n;
    logic [63:0] exp_d;
    @(negedge clk);
    arid    = id;
    araddr  = addr;
    arlen   = len;
    arsize  = size;
    arburst = burst;
    arvalid = 1'b1;
    n = 0;
    while (s_axi_arready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("ar_handshake", (n < 20), 64'd1);
    if (rbw) begin
      mem_we    = 1'b1;
      mem_waddr = addr[14:3];
      mem_wdata = ~K;
    end
    @(posedge clk);
    #1;
    arvalid = 1'b0;
    mem_we  = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      @(negedge clk);
      exp_d = exp_err[i] ? 64'h0 : mem_model[exp_addr[i][14:3]];
      check_eq("rvalid", s_axi_rvalid, 64'd1);
      check_eq("rdata", s_axi_rdata, exp_d);
      check_eq("rresp", s_axi_rresp, exp_err[i] ? 64'd2 : 64'd0);
      check_eq("rlast", s_axi_rlast, (i == int'(len)));
      check_eq("rid", s_axi_rid, id);
      if (i == stall_idx) begin
        rready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check_eq("hold_rvalid", s_axi_rvalid, 64'd1);
          check_eq("hold_rdata", s_axi_rdata, exp_d);
          check_eq("hold_rlast", s_axi_rlast, (i == int'(len)));
        end
        rready = 1'b1;
      end
      if (i == abort_idx) begin
        reset = 1'b0;
        @(negedge clk);
        check_eq("abort_rvalid", s_axi_rvalid, 64'd0);
        check_eq("abort_arready", s_axi_arready, 64'd0);
        reset = 1'b1;
        @(negedge clk);
        check_eq("post_reset_arready", s_axi_arready, 64'd1);
        return;
      end
    end
    @(negedge clk);
    check_eq("idle_rvalid", s_axi_rvalid, 64'd0);
    check_eq("idle_arready", s_axi_arready, 64'd1);
    if (rbw) mem_model[addr[14:3]] = ~K;
  endtask

  initial begin
    reset     = 1'b0;
    arid      = '0;
    araddr    = '0;
    arlen     = 8'd0;
    arsize    = 3'd0;
    arburst   = 2'd0;
    arvalid   = 1'b0;
    rready    = 1'b1;
    mem_we    = 1'b0;
    mem_waddr = 12'd0;
    mem_wdata = 64'd0;

    // Preload while held in reset.
    for (int k = 0; k < DEPTH; k++) begin
      @(negedge clk);
      mem_we       = 1'b1;
      mem_waddr    = 12'(k);
      mem_wdata    = 64'(k) * K;
      mem_model[k] = 64'(k) * K;
    end
    @(negedge clk);
    mem_we = 1'b0;
    @(negedge clk);
    check_eq("rst_arready", s_axi_arready, 64'd0);
    check_eq("rst_rvalid", s_axi_rvalid, 64'd0);
    check_eq("rst_rlast", s_axi_rlast, 64'd0);
    check_eq("rst_rresp", s_axi_rresp, 64'd0);
    check_eq("rst_rid", s_axi_rid, 64'd0);
    check_eq("rst_rdata", s_axi_rdata, 64'd0);
    reset = 1'b1;

    // INCR 8 beats from 0x40, stall on beat 2.
    for (int i = 0; i < 8; i++) set_exp(i, 64'h40 + 64'(8 * i), 1'b0);
    run_burst(13'd5, 64'h40, 8'd7, 3'd3, 2'd1, 1, -1, 1'b0);

    // WRAP 4 beats from 0x58.
    set_exp(0, 64'h58, 1'b0);
    set_exp(1, 64'h40, 1'b0);
    set_exp(2, 64'h48, 1'b0);
    set_exp(3, 64'h50, 1'b0);
    run_burst(13'd9, 64'h58, 8'd3, 3'd3, 2'd2, -1, -1, 1'b0);

    // Last word then one past the end of memory.
    set_exp(0, 64'h7FF8, 1'b0);
    set_exp(1, 64'h8000, 1'b1);
    run_burst(13'h1ABC, 64'h7FF8, 8'd1, 3'd3, 2'd1, -1, -1, 1'b0);

    // Illegal WRAP length.
    for (int i = 0; i < 3; i++) set_exp(i, 64'h40, 1'b1);
    run_burst(13'd2, 64'h40, 8'd2, 3'd3, 2'd2, -1, -1, 1'b0);

    // Oversized beat.
    for (int i = 0; i < 2; i++) set_exp(i, 64'h40, 1'b1);
    run_burst(13'd3, 64'h40, 8'd1, 3'd4, 2'd1, -1, -1, 1'b0);

    // Sub-word INCR returns whole aligned words.
    set_exp(0, 64'h44, 1'b0);
    set_exp(1, 64'h48, 1'b0);
    run_burst(13'd4, 64'h44, 8'd1, 3'd2, 2'd1, -1, -1, 1'b0);

    // Reset during beat 3 of 8.
    for (int i = 0; i < 8; i++) set_exp(i, 64'h80 + 64'(8 * i), 1'b0);
    run_burst(13'd7, 64'h80, 8'd7, 3'd3, 2'd1, -1, 2, 1'b0);

    // FIXED burst after reset.
    for (int i = 0; i < 3; i++) set_exp(i, 64'h18, 1'b0);
    run_burst(13'd11, 64'h18, 8'd2, 3'd3, 2'd0, -1, -1, 1'b0);

    // Preload write to the same word on the AR handshake edge: old data returned.
    set_exp(0, 64'h20, 1'b0);
    run_burst(13'd12, 64'h20, 8'd0, 3'd3, 2'd0, -1, -1, 1'b1);
    set_exp(0, 64'h20, 1'b0);
    run_burst(13'd13, 64'h20, 8'd0, 3'd3, 2'd0, -1, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
